// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with scan-code decoding for the rsa key-entry stage.
// One pending event is held while stall is high; the newest event wins on overrun.
module ps2_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] ps2_data_o,
    output logic       ps2_valid_o,
    output logic       ps2_done_o,
    output logic       ps2_reset_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;
    typedef enum logic [1:0] {EV_DATA, EV_DONE, EV_RESET} ev_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   brk_q, brk_d;
    logic                   pend_q, pend_d;
    ev_t                    pend_ev_q, pend_ev_d;
    logic [7:0]             pend_byte_q, pend_byte_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   reset_q, reset_d;
    logic [7:0]             data_q, data_d;
    logic                   overrun_q, overrun_d;

    logic ps2_clk_s, ps2_dat_s, fall, in_check, frame_ok, new_evt;
    ev_t  new_ev, out_ev;
    logic [7:0] out_byte;
    logic out_fire;

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;
    assign in_check  = (state_q == S_CHECK);
    assign frame_ok  = (^shift_q[8:0]) & shift_q[9];

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
        clk_prev_d = ps2_clk_s;
        if (fall)
            tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT_CYCLES))
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + TW'(1);
    end

    // Frame FSM: shift start-stripped bits LSB first so data lands in [7:0], parity [8], stop [9].
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (fall && !ps2_dat_s) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    shift_d   = {ps2_dat_s, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9)
                        state_d = S_CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        brk_d   = brk_q;
        new_evt = 1'b0;
        new_ev  = EV_DATA;
        if (in_check && frame_ok) begin
            if (shift_q[7:0] == 8'hE0) begin
                brk_d = brk_q;
            end else if (shift_q[7:0] == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                new_evt = 1'b1;
                case (shift_q[7:0])
                    8'h5A:   new_ev = EV_DONE;
                    8'h76:   new_ev = EV_RESET;
                    default: new_ev = EV_DATA;
                endcase
            end
        end
    end

    // An older pending event is presented before a same-cycle new one, which then becomes pending.
    always_comb begin
        pend_d      = pend_q;
        pend_ev_d   = pend_ev_q;
        pend_byte_d = pend_byte_q;
        overrun_d   = overrun_q;
        out_fire    = 1'b0;
        out_ev      = EV_DATA;
        out_byte    = 8'h00;
        if (!stall) begin
            if (pend_q) begin
                out_fire    = 1'b1;
                out_ev      = pend_ev_q;
                out_byte    = pend_byte_q;
                pend_d      = new_evt;
                pend_ev_d   = new_ev;
                pend_byte_d = shift_q[7:0];
            end else if (new_evt) begin
                out_fire = 1'b1;
                out_ev   = new_ev;
                out_byte = shift_q[7:0];
            end
        end else if (new_evt) begin
            if (pend_q)
                overrun_d = 1'b1;
            pend_d      = 1'b1;
            pend_ev_d   = new_ev;
            pend_byte_d = shift_q[7:0];
        end
        valid_d = out_fire && (out_ev == EV_DATA);
        done_d  = out_fire && (out_ev == EV_DONE);
        reset_d = out_fire && (out_ev == EV_RESET);
        data_d  = valid_d ? out_byte : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            tmo_q       <= '0;
            brk_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_ev_q   <= EV_DATA;
            pend_byte_q <= 8'h00;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            reset_q     <= 1'b0;
            data_q      <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            brk_q       <= brk_d;
            pend_q      <= pend_d;
            pend_ev_q   <= pend_ev_d;
            pend_byte_q <= pend_byte_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            reset_q     <= reset_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ps2_data_o  = data_q;
    assign ps2_valid_o = valid_q;
    assign ps2_done_o  = done_q;
    assign ps2_reset_o = reset_q;
    assign frame_err_o = in_check & ~frame_ok;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames, predicts the decoded event stream from scan-code
// rules, and checks every cycle's outputs against that prediction.
module tb_ps2_rx;

    localparam int TO   = 5000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Dat = 1'b1;
    logic [7:0] dataOut;
    logic       validOut, doneOut, resetOut, frameErr, overrun;

    ps2_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .ps2_clk_i   (ps2Clk),
        .ps2_dat_i   (ps2Dat),
        .ps2_data_o  (dataOut),
        .ps2_valid_o (validOut),
        .ps2_done_o  (doneOut),
        .ps2_reset_o (resetOut),
        .frame_err_o (frameErr),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_s;

    ev_s  expQ[$];
    ev_s  held;
    logic heldValid = 1'b0;
    logic modelBrk = 1'b0;
    logic expOverrun = 1'b0;
    int   expErrs = 0;
    int   checks = 0;
    int   errors = 0;
    logic checkEn = 1'b0;
    logic lastStall = 1'b0;

    // Shared comparison point so every check is counted and reported the same way.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s);
        @(posedge clk);
        #1 stall = s;
    endtask

    // Scan-code rules: E0 ignored, F0 arms break, next code after break is swallowed.
    task automatic modelFrame(input logic [7:0] b, input logic good);
        ev_s e;
        if (!good) begin
            expErrs++;
        end else if (b == 8'hE0) begin
        end else if (b == 8'hF0) begin
            modelBrk = 1'b1;
        end else if (modelBrk) begin
            modelBrk = 1'b0;
        end else begin
            e.kind = (b == 8'h5A) ? 1 : (b == 8'h76) ? 2 : 0;
            e.data = (e.kind == 0) ? b : 8'h00;
            if (stall) begin
                if (heldValid)
                    expOverrun = 1'b1;
                held      = e;
                heldValid = 1'b1;
            end else begin
                expQ.push_back(e);
            end
        end
    endtask

    task automatic releaseStall();
        if (heldValid)
            expQ.push_back(held);
        heldValid = 1'b0;
        applyStimulus(1'b0);
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n, input logic measure,
                            output int lat, output logic [7:0] latData);
        lat     = -1;
        latData = 8'h00;
        for (int i = 0; i < n; i++) begin
            ps2Dat = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2Clk = 1'b0;
            if (measure && i == n - 1) begin
                for (int k = 1; k <= 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (validOut | doneOut | resetOut | frameErr) begin
                        lat     = k;
                        latData = dataOut;
                        break;
                    end
                end
            end
            repeat (HALF) @(posedge clk);
            #1 ps2Clk = 1'b1;
        end
        ps2Dat = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic good, input logic measure,
                             output int lat, output logic [7:0] latData);
        logic par;
        par = good ? ~^b : ^b;
        modelFrame(b, good);
        sendBits({1'b1, par, b, 1'b0}, 11, measure, lat, latData);
        repeat (10) @(posedge clk);
    endtask

    always @(posedge clk) lastStall <= stall;

    // Every-cycle comparison against the predicted event stream.
    always @(negedge clk) begin
        if (checkEn) begin
            logic anyStrobe;
            ev_s  e;
            int   kind;
            anyStrobe = validOut | doneOut | resetOut;
            checkOutput("onehot", 32'(validOut) + 32'(doneOut) + 32'(resetOut) <= 1, 1);
            if (!validOut)
                checkOutput("data_idle", dataOut, 0);
            if (lastStall)
                checkOutput("stall_gate", anyStrobe, 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", anyStrobe, 0);
            end else if (anyStrobe) begin
                e    = expQ.pop_front();
                kind = validOut ? 0 : doneOut ? 1 : 2;
                checkOutput("ev_kind", kind, e.kind);
                checkOutput("ev_data", dataOut, e.data);
            end
            if (expErrs == 0)
                checkOutput("unexpected_err", frameErr, 0);
            else if (frameErr)
                expErrs--;
        end
    end

    initial begin
        int         lat;
        logic [7:0] latData;

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", validOut, 0);
        checkOutput("rst_done", doneOut, 0);
        checkOutput("rst_reset", resetOut, 0);
        checkOutput("rst_data", dataOut, 0);
        checkOutput("rst_err", frameErr, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkEn = 1'b1;

        sendFrame(8'h1C, 1'b1, 1'b1, lat, latData);
        checkOutput("make_latency", lat, 4);
        checkOutput("make_data_literal", latData, 8'h1C);

        sendFrame(8'hF0, 1'b1, 1'b0, lat, latData);
        sendFrame(8'h1C, 1'b1, 1'b0, lat, latData);
        sendFrame(8'h32, 1'b1, 1'b1, lat, latData);
        checkOutput("after_break_literal", latData, 8'h32);

        sendFrame(8'hE0, 1'b1, 1'b0, lat, latData);
        sendFrame(8'h5A, 1'b1, 1'b0, lat, latData);
        sendFrame(8'h76, 1'b1, 1'b0, lat, latData);

        sendFrame(8'h1C, 1'b0, 1'b1, lat, latData);
        checkOutput("err_latency", lat, 3);
        sendFrame(8'h1C, 1'b1, 1'b0, lat, latData);

        sendBits({6'b0, 4'b1101, 1'b0}, 5, 1'b0, lat, latData);
        repeat (TO + 10) @(posedge clk);
        sendFrame(8'h2D, 1'b1, 1'b0, lat, latData);

        applyStimulus(1'b1);
        sendFrame(8'h1C, 1'b1, 1'b0, lat, latData);
        repeat (20) @(posedge clk);
        releaseStall();
        repeat (10) @(posedge clk);
        checkOutput("overrun_single", overrun, expOverrun);

        applyStimulus(1'b1);
        sendFrame(8'h1C, 1'b1, 1'b0, lat, latData);
        sendFrame(8'h32, 1'b1, 1'b0, lat, latData);
        releaseStall();
        repeat (10) @(posedge clk);
        checkOutput("overrun_model", overrun, expOverrun);
        checkOutput("overrun_literal", overrun, 1);
        repeat (50) @(posedge clk);
        checkOutput("overrun_sticky", overrun, 1);

        @(posedge clk);
        #1 rst = 1'b1;
        modelBrk   = 1'b0;
        heldValid  = 1'b0;
        expOverrun = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("overrun_cleared", overrun, 0);

        repeat (10) @(posedge clk);
        checkOutput("events_drained", expQ.size(), 0);
        checkOutput("errs_drained", expErrs, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
